hadamard_sched: RTL and testbench

Stage/group scheduler for the radix-4 FFT engine built around `complexhadamard`. It walks all stages of an N = 4^M point radix-4 DIF transform. For each group it:
- issues one read request to the ping-pong sample buffer,
- drives the butterfly pipeline `start` and the twiddle ROM index,
- tracks in-flight groups through the fixed pipeline latency,
- generates the matching write-back request into the opposite bank.

It sits between the top-level FFT control (start/done) and the buffer, twiddle ROM and butterfly datapath.

---
 rtl/hadamard_sched_pkg.sv | 23 ++
 rtl/hadamard_sched_if.sv | 36 +++
 rtl/hadamard_addr_gen.sv | 45 ++++
 rtl/hadamard_sched.sv | 146 ++++++++++++++
 tb/tb_hadamard_sched.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hadamard_sched_pkg.sv
// Shared types and helpers for the radix-4 stage/group scheduler.
package hadamard_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reverse the low ndig base-4 digits of v.
    function automatic logic [31:0] digitrev4(input logic [31:0] v, input int unsigned ndig);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < ndig) begin
                r = r | (((v >> (2 * i)) & 32'd3) << (2 * (ndig - 1 - i)));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hadamard_sched_if.sv
// Scheduler control / buffer-request bundle; master = scheduler side.
interface hadamard_sched_if #(
    parameter int unsigned M = 2
);
    localparam int unsigned ADDR_W = 2 * M;
    localparam int unsigned SH_W   = $clog2(ADDR_W);
    localparam int unsigned ST_W   = $clog2(M) + 1;

    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic [ST_W-1:0]   stage;
    logic              rd_en;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_base;
    logic [SH_W-1:0]   rd_sh;
    logic [ADDR_W-1:0] tw_idx;
    logic              pipe_start;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_base;
    logic [SH_W-1:0]   wr_sh;

    modport master (
        input  start, hold,
        output busy, done, stage, rd_en, rd_bank, rd_base, rd_sh, tw_idx,
               pipe_start, wr_en, wr_bank, wr_base, wr_sh
    );

    modport slave (
        output start, hold,
        input  busy, done, stage, rd_en, rd_bank, rd_base, rd_sh, tw_idx,
               pipe_start, wr_en, wr_bank, wr_base, wr_sh
    );
endinterface

// File: rtl/hadamard_addr_gen.sv
// Combinational (group, stage) -> read/twiddle/write address mapping.
// HADAMARD_SCHED_DIGITREV_EN: last stage writes in natural (digit-reversed) order.
module hadamard_addr_gen
    import hadamard_sched_pkg::*;
#(
    parameter  int unsigned M      = 2,
    localparam int unsigned ADDR_W = 2 * M,
    localparam int unsigned SH_W   = $clog2(ADDR_W),
    localparam int unsigned ST_W   = $clog2(M) + 1,
    localparam int unsigned G_W    = ADDR_W - 2
) (
    input  logic [G_W-1:0]    g,
    input  logic [ST_W-1:0]   stage,
    output logic [ADDR_W-1:0] rd_base,
    output logic [SH_W-1:0]   rd_sh,
    output logic [ADDR_W-1:0] tw_idx,
    output logic [ADDR_W-1:0] wr_base,
    output logic [SH_W-1:0]   wr_sh
);

    logic [ADDR_W-1:0] g_w;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] b;

    // k selects the position inside the span, b the butterfly block.
    always_comb begin
        rd_sh   = SH_W'(2 * (M - 1 - 32'(stage)));
        g_w     = ADDR_W'(g);
        mask    = (ADDR_W'(1) << rd_sh) - ADDR_W'(1);
        k       = g_w & mask;
        b       = g_w >> rd_sh;
        rd_base = ((b << rd_sh) << 2) | k;
        tw_idx  = k << {stage, 1'b0};
        wr_base = rd_base;
        wr_sh   = rd_sh;
`ifdef HADAMARD_SCHED_DIGITREV_EN
        if (32'(stage) == M - 1) begin
            wr_base = ADDR_W'(digitrev4(32'(g), M - 1));
            wr_sh   = SH_W'(2 * (M - 1));
        end
`endif
    end

endmodule

// File: rtl/hadamard_sched.sv
// Stage/group scheduler for the radix-4 DIF FFT around complexhadamard.
// HADAMARD_SCHED_DIGITREV_EN selects natural-order write-back on the last stage.
module hadamard_sched
    import hadamard_sched_pkg::*;
#(
    parameter int unsigned M        = 2,
    parameter int unsigned PIPE_LAT = 5
) (
    input logic             clk,
    input logic             rst,
    hadamard_sched_if.master bus
);

    localparam int unsigned ADDR_W = 2 * M;
    localparam int unsigned SH_W   = $clog2(ADDR_W);
    localparam int unsigned ST_W   = $clog2(M) + 1;
    localparam int unsigned G_W    = ADDR_W - 2;
    localparam logic [ST_W-1:0] LAST_ST = ST_W'(M - 1);

    state_t            state, state_n;
    logic [G_W-1:0]    g, ag_g;
    logic [ST_W-1:0]   stage, ag_stage;
    logic              issue;
    logic              drain_end;

    logic [ADDR_W-1:0] ag_rd_base, ag_tw, ag_wr_base;
    logic [SH_W-1:0]   ag_rd_sh, ag_wr_sh;

    logic              busy_q, done_q, rd_en_q, rd_bank_q;
    logic [ADDR_W-1:0] rd_base_q, tw_q, wb_q;
    logic [SH_W-1:0]   rd_sh_q, wsh_q;

    logic [PIPE_LAT:0] vld;
    logic [ADDR_W-1:0] base_d [0:PIPE_LAT];
    logic [SH_W-1:0]   sh_d   [0:PIPE_LAT];
    logic [PIPE_LAT:0] bank_d;

    hadamard_addr_gen #(.M(M)) u_addr (
        .g       (ag_g),
        .stage   (ag_stage),
        .rd_base (ag_rd_base),
        .rd_sh   (ag_rd_sh),
        .tw_idx  (ag_tw),
        .wr_base (ag_wr_base),
        .wr_sh   (ag_wr_sh)
    );

    // Last write-back of a stage: nothing younger is still in the pipe.
    assign drain_end = vld[PIPE_LAT] && (vld[PIPE_LAT-1:0] == '0);

    // Next state and the (group, stage) pair issued at this edge.
    always_comb begin
        state_n  = state;
        issue    = 1'b0;
        ag_g     = g;
        ag_stage = stage;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n  = ST_ISSUE;
                    ag_g     = '0;
                    ag_stage = '0;
                end
            end
            ST_ISSUE: begin
                if (!bus.hold) begin
                    issue = 1'b1;
                    if (&g) state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_end) begin
                    if (stage != LAST_ST) begin
                        state_n  = ST_ISSUE;
                        ag_g     = '0;
                        ag_stage = stage + ST_W'(1);
                        issue    = !bus.hold;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
        endcase
    end

    // State, counters, issue registers and the in-flight delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            g         <= '0;
            stage     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_base_q <= '0;
            rd_sh_q   <= '0;
            tw_q      <= '0;
            wb_q      <= '0;
            wsh_q     <= '0;
            vld       <= '0;
            bank_d    <= '0;
            for (int i = 0; i <= PIPE_LAT; i++) begin
                base_d[i] <= '0;
                sh_d[i]   <= '0;
            end
        end else begin
            state     <= state_n;
            busy_q    <= (state_n != ST_IDLE);
            done_q    <= (state_n == ST_DONE);
            g         <= issue ? ag_g + G_W'(1) : ag_g;
            stage     <= ag_stage;
            rd_en_q   <= issue;
            rd_bank_q <= ag_stage[0];
            rd_base_q <= issue ? ag_rd_base : '0;
            rd_sh_q   <= issue ? ag_rd_sh : '0;
            tw_q      <= issue ? ag_tw : '0;
            wb_q      <= issue ? ag_wr_base : '0;
            wsh_q     <= issue ? ag_wr_sh : '0;
            vld       <= {vld[PIPE_LAT-1:0], rd_en_q};
            bank_d    <= {bank_d[PIPE_LAT-1:0], rd_en_q & ~rd_bank_q};
            base_d[0] <= wb_q;
            sh_d[0]   <= wsh_q;
            for (int i = 1; i <= PIPE_LAT; i++) begin
                base_d[i] <= base_d[i-1];
                sh_d[i]   <= sh_d[i-1];
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.stage      = stage;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_bank    = rd_bank_q;
    assign bus.rd_base    = rd_base_q;
    assign bus.rd_sh      = rd_sh_q;
    assign bus.tw_idx     = tw_q;
    assign bus.pipe_start = vld[0];
    assign bus.wr_en      = vld[PIPE_LAT];
    assign bus.wr_bank    = bank_d[PIPE_LAT];
    assign bus.wr_base    = base_d[PIPE_LAT];
    assign bus.wr_sh      = sh_d[PIPE_LAT];

endmodule

// File: tb/tb_hadamard_sched.sv
// Scoreboard bench for hadamard_sched (M=2 and M=3 instances, PIPE_LAT=5).
module tb_hadamard_sched;

    localparam int PL = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hadamard_sched_if #(.M(2)) bus2 ();
    hadamard_sched_if #(.M(3)) bus3 ();

    hadamard_sched #(.M(2), .PIPE_LAT(PL)) u2 (.clk(clk), .rst(rst), .bus(bus2));
    hadamard_sched #(.M(3), .PIPE_LAT(PL)) u3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        int inst;
        int cyc;
        int val;
    } item_t;

    item_t rq[$];
    item_t wq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    t0    = 0;
    int    exp_done = 0;
    bit    done_flag = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_or(input int i);
        if (i == 0)
            return int'(|{bus2.busy, bus2.done, bus2.stage, bus2.rd_en, bus2.rd_bank, bus2.rd_base,
                          bus2.rd_sh, bus2.tw_idx, bus2.pipe_start, bus2.wr_en, bus2.wr_bank,
                          bus2.wr_base, bus2.wr_sh});
        return int'(|{bus3.busy, bus3.done, bus3.stage, bus3.rd_en, bus3.rd_bank, bus3.rd_base,
                      bus3.rd_sh, bus3.tw_idx, bus3.pipe_start, bus3.wr_en, bus3.wr_bank,
                      bus3.wr_base, bus3.wr_sh});
    endfunction

    function automatic int busy_of(input int i);
        return (i == 0) ? int'(bus2.busy) : int'(bus3.busy);
    endfunction

    task automatic set_start(input int i, input logic v);
        if (i == 0) bus2.start = v;
        else        bus3.start = v;
    endtask

    // Expected read/write sequence; hold sampled at edges h0..h1 blocks issue there.
    task automatic push_model(input int inst, input int m, input int h0, input int h1);
        int c, last, ng, sh, k, b, base, wbase, wsh;
        item_t it;
        ng = 1 << (2 * m - 2);
        c = 1;
        last = 0;
        for (int s = 0; s < m; s++) begin
            for (int g = 0; g < ng; g++) begin
                while (c >= h0 && c <= h1) c++;
                sh   = 2 * (m - 1 - s);
                k    = g % (1 << sh);
                b    = g >> sh;
                base = (b << (sh + 2)) | k;
                it.inst = inst;
                it.cyc  = c;
                it.val  = (s << 24) | ((s & 1) << 20) | (sh << 16) | (base << 8) | (k << (2 * s));
                rq.push_back(it);
                wbase = base;
                wsh   = sh;
`ifdef HADAMARD_SCHED_DIGITREV_EN
                if (s == m - 1) begin
                    wbase = 0;
                    for (int d = 0; d < m - 1; d++) wbase = wbase * 4 + ((g >> (2 * d)) & 3);
                    wsh = 2 * (m - 1);
                end
`endif
                it.cyc = c + 1 + PL;
                it.val = ((~s & 1) << 20) | (wsh << 16) | (wbase << 8);
                wq.push_back(it);
                last = c;
                c++;
            end
            c = last + PL + 2;
        end
        exp_done = c;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        bit prev_rd [2];
        prev_rd[0] = 1'b0;
        prev_rd[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int rel, rv, wv, en_r, en_w, ps, dn;
                item_t it;
                rel = cyc - t0;
                if (i == 0) begin
                    en_r = int'(bus2.rd_en); en_w = int'(bus2.wr_en);
                    ps = int'(bus2.pipe_start); dn = int'(bus2.done);
                    rv = (int'(bus2.stage) << 24) | (int'(bus2.rd_bank) << 20) | (int'(bus2.rd_sh) << 16)
                       | (int'(bus2.rd_base) << 8) | int'(bus2.tw_idx);
                    wv = (int'(bus2.wr_bank) << 20) | (int'(bus2.wr_sh) << 16) | (int'(bus2.wr_base) << 8);
                end else begin
                    en_r = int'(bus3.rd_en); en_w = int'(bus3.wr_en);
                    ps = int'(bus3.pipe_start); dn = int'(bus3.done);
                    rv = (int'(bus3.stage) << 24) | (int'(bus3.rd_bank) << 20) | (int'(bus3.rd_sh) << 16)
                       | (int'(bus3.rd_base) << 8) | int'(bus3.tw_idx);
                    wv = (int'(bus3.wr_bank) << 20) | (int'(bus3.wr_sh) << 16) | (int'(bus3.wr_base) << 8);
                end
                if (en_r != 0) begin
                    if (rq.size() == 0 || rq[0].inst != i) check_eq("rd_extra", rel, -1);
                    else begin
                        it = rq.pop_front();
                        check_eq("rd_cyc", rel, it.cyc);
                        check_eq("rd_fields", rv, it.val);
                    end
                end
                if (en_w != 0) begin
                    if (wq.size() == 0 || wq[0].inst != i) check_eq("wr_extra", rel, -1);
                    else begin
                        it = wq.pop_front();
                        check_eq("wr_cyc", rel, it.cyc);
                        check_eq("wr_fields", wv, it.val);
                    end
                end
                if (ps != 0 || prev_rd[i]) check_eq("pipe_start", ps, int'(prev_rd[i]));
                prev_rd[i] = (en_r != 0);
                if (dn != 0) begin
                    check_eq("done_cyc", rel, exp_done);
                    done_flag = 1'b1;
                end
            end
        end
    end

    // One transform: start sampled at the next edge (cycle 0), inputs set mid-cycle.
    task automatic run(input int inst, input int m, input int h0, input int h1,
                       input int rst_at, input bit keep, input bit expect_done);
        int r;
        set_start(inst, 1'b1);
        t0 = cyc + 1;
        done_flag = 1'b0;
        push_model(inst, m, h0, h1);
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            r = cyc - t0;
            if (done_flag) begin
                check_eq("busy_after_done", busy_of(inst), 0);
                break;
            end
            set_start(inst, keep);
            bus2.hold = (r + 1 >= h0 && r + 1 <= h1);
            bus3.hold = bus2.hold;
            if (r == rst_at) rst = 1'b1;
            if (r == rst_at + 1) begin
                check_eq("rst_outs", outs_or(inst), 0);
                // two stage-0 writes plus all eight stage-1 transfers were still pending
                check_eq("rst_pending", rq.size() + wq.size(), 10);
                rq.delete();
                wq.delete();
                rst = 1'b0;
            end
        end
        if (expect_done) check_eq("done_seen", int'(done_flag), 1);
        else             check_eq("no_done", int'(done_flag), 0);
        check_eq("queue_empty", rq.size() + wq.size(), 0);
        bus2.hold = 1'b0;
        bus3.hold = 1'b0;
        if (!keep) set_start(inst, 1'b0);
    endtask

    initial begin
        bus2.start = 1'b0; bus2.hold = 1'b0;
        bus3.start = 1'b0; bus3.hold = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_outs_m2", outs_or(0), 0);
        check_eq("reset_outs_m3", outs_or(1), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;
        run(0, 2, 100, 99, -5, 1'b0, 1'b1);   // plain run, done at 21
        run(0, 2, 2, 3, -5, 1'b0, 1'b1);      // hold gaps at 2-3, done at 23
        run(0, 2, 100, 99, 8, 1'b0, 1'b0);    // reset mid-transform
        run(0, 2, 100, 99, -5, 1'b1, 1'b1);   // start held through DONE
        run(0, 2, 100, 99, -5, 1'b0, 1'b1);   // the single restart from IDLE
        run(1, 3, 100, 99, -5, 1'b0, 1'b1);   // M=3, done at 67
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
